run_controller: RTL and testbench
=================================

# run_controller

Parametrised clock-enable and debug run controller for the EDiC CPU. It sits between the board-level oscillator/buttons/switches and `datapath`, generating the single `o_cpuEn` clock enable the datapath qualifies every register update with. It supports debounced single-cycle and single-instruction stepping, rate-divided free run, and a bank of programmable PC breakpoints with skip-once resume.

## Interface
- `ADDR_WIDTH`, 16, PC / breakpoint address width
- `NUM_BREAKPOINTS`, 4, number of breakpoint comparators (≥1); `BP_IDX_W = max(1,$clog2(NUM_BREAKPOINTS))`
- `DEBOUNCE_CYCLES`, 1000, consecutive stable synchronized cycles required to accept a button level
- `DIV_WIDTH`, 8, width of run-rate divider
- `i_oszClk` in 1 — system clock
- `i_reset` in 1 — asynchronous, active-high reset
- `i_btnStep` in 1 — raw step button, 1 = pressed
- `i_swInstrNCycle` in 1 — 1 = step whole instruction, 0 = step one cycle
- `i_swStepNRun` in 1 — 1 = step mode, 0 = run mode
- `i_swEnableBreakpoint` in 1 — 1 = breakpoints active
- `i_instrDone` in 1 — datapath: current enabled cycle is the last microcycle of an instruction
- `i_pc` in ADDR_WIDTH — address of the next instruction, valid whenever `i_instrDone`=1
- `i_bpWrEn` in 1 — write breakpoint entry
- `i_bpIdx` in BP_IDX_W — entry to write
- `i_bpAddr` in ADDR_WIDTH — breakpoint address
- `i_bpValid` in 1 — valid bit written with the entry
- `i_runDiv` in DIV_WIDTH — run mode: one enable every `i_runDiv+1` cycles
- `i_clrCount` in 1 — synchronous clear of cycle counter
- `o_cpuEn` out 1 — datapath clock enable
- `o_halted` out 1 — 1 while in BREAK
- `o_bpHitIdx` out BP_IDX_W — index of last breakpoint hit
- `o_state` out 3 — FSM state encoding
- `o_cycleCount` out 32 — count of enabled cycles

## Operation
- `i_btnStep` and all three switches pass through 2-FF synchronizers. Switches are not debounced.
- Step button debounce: counter restarts on every change of the synced level; the new level is accepted after DEBOUNCE_CYCLES stable cycles. A 0→1 transition of the accepted level produces a one-cycle `stepReq`.
- FSM states: STOPPED=0, STEP_CYCLE=1, STEP_INSTR=2, RUN=3, BREAK=4.
  - STOPPED:
    - run switch (`i_swStepNRun`=0) → RUN.
    - Otherwise `stepReq` → STEP_INSTR if `i_swInstrNCycle` else STEP_CYCLE.
    - `stepReq` is ignored in run mode.
  - STEP_CYCLE: `o_cpuEn`=1 for exactly one cycle → STOPPED.
  - STEP_INSTR: `o_cpuEn`=1 every cycle; `i_instrDone` → STOPPED.
  - RUN:
    - `o_cpuEn`=1 when divider count = 0. The count reloads from `i_runDiv` after each enable; a new `i_runDiv` value takes effect at the next reload.
    - On a boundary (`i_instrDone & o_cpuEn`), evaluated in priority order:
      - breakpoint match → BREAK;
      - else step switch set → STOPPED (drain to instruction boundary).
  - BREAK: `o_cpuEn`=0, `o_halted`=1.
    - `stepReq` → RUN with skip-once set.
    - Step switch set → STOPPED.
- Breakpoint match requires all of: `i_swEnableBreakpoint`=1, an entry with valid=1 and addr == `i_pc`, and skip-once clear.
  - On multiple matches, the lowest index is latched into `o_bpHitIdx`.
  - Skip-once clears at the next boundary.
- Breakpoint write takes effect the cycle after `i_bpWrEn`. A same-cycle compare uses the old contents.
- `o_cpuEn` decodes from registered state/counter only; there is no combinational path from any input.

## Timing
- Reset values: `o_cpuEn`=0, `o_halted`=0, `o_bpHitIdx`=0, `o_state`=0, `o_cycleCount`=0, all breakpoints invalid, debounced level 0, divider count 0, skip-once 0.
- Reset asserted mid-operation forces all of the above immediately (asynchronously); no pending step survives.
- Raw step press → `stepReq`: 2 + DEBOUNCE_CYCLES cycles. `o_cpuEn` rises the cycle after `stepReq`.
- Boundary → next state is 1 cycle: `o_cpuEn` is low in the cycle after a breaking, draining or STEP_INSTR-ending `i_instrDone`.
- Entering RUN: first `o_cpuEn` in the first RUN cycle (divider count 0).

## Configuration
- `RUNCTRL_CYCLE_COUNTER_EN` defined:
  - `o_cycleCount` increments on every `o_cpuEn` cycle and saturates at 0xFFFFFFFF.
  - `i_clrCount` clears it to 0 and wins over increment.
- Undefined: `o_cycleCount` is constant 0 and `i_clrCount` is ignored.

## Test plan
All scenarios use ADDR_WIDTH=16, NUM_BREAKPOINTS=4, DEBOUNCE_CYCLES=4, counter macro defined.
- Cycle step:
  - Step mode, cycle, hold `i_btnStep` 12 cycles → exactly one `o_cpuEn` pulse, 7 cycles after press.
  - A 2-cycle glitch → no pulse.
- Instruction step: `i_instrDone` on the 3rd enabled cycle → `o_cpuEn` high for exactly 3 cycles, then `o_state`=0.
- Rate divider: run mode, `i_runDiv`=2 for 30 cycles → `o_cpuEn` every 3rd cycle, `o_cycleCount`=10.
- Breakpoint hit and resume:
  - bp[2]=0x0040 valid, run, `i_instrDone` with `i_pc`=0x0040 → next cycle `o_state`=4, `o_halted`=1, `o_bpHitIdx`=2, `o_cpuEn`=0.
  - Step press → RUN with no re-break at 0x0040 until the following boundary.
- Match priority and disable:
  - bp[1] and bp[3] both 0x0100 → `o_bpHitIdx`=1.
  - `i_swEnableBreakpoint`=0 → no halt.
- Async reset mid-RUN → `o_cpuEn`=0 and `o_state`=0 the same cycle, breakpoints invalid, `o_cycleCount`=0.

Source files
------------

// File: rtl/run_controller.sv
// run_controller: clock-enable and debug run controller for the EDiC CPU.
// Define RUNCTRL_CYCLE_COUNTER_EN to build the enabled-cycle counter.
module run_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_BREAKPOINTS = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DIV_WIDTH = 8,
  localparam int BP_IDX_W =
    (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1
) (
  input  logic                  i_oszClk,
  input  logic                  i_reset,
  input  logic                  i_btnStep,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swStepNRun,
  input  logic                  i_swEnableBreakpoint,
  input  logic                  i_instrDone,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_bpWrEn,
  input  logic [BP_IDX_W-1:0]   i_bpIdx,
  input  logic [ADDR_WIDTH-1:0] i_bpAddr,
  input  logic                  i_bpValid,
  input  logic [DIV_WIDTH-1:0]  i_runDiv,
  input  logic                  i_clrCount,
  output logic                  o_cpuEn,
  output logic                  o_halted,
  output logic [BP_IDX_W-1:0]   o_bpHitIdx,
  output logic [2:0]            o_state,
  output logic [31:0]           o_cycleCount
);

  typedef enum logic [2:0] {
    STOPPED    = 3'd0,
    STEP_CYCLE = 3'd1,
    STEP_INSTR = 3'd2,
    RUN        = 3'd3,
    BREAK      = 3'd4
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] btnSync;
  logic [1:0] instrSync;
  logic [1:0] bpEnSync;
  logic [1:0] stepRunSync;
  logic       btnS;
  logic       instrS;
  logic       bpEnS;
  logic       stepRunS;

  logic [DB_W-1:0] dbCnt;
  logic            dbLevel;
  logic            stepReq;

  logic [ADDR_WIDTH-1:0] bpAddr [NUM_BREAKPOINTS];
  logic [NUM_BREAKPOINTS-1:0] bpValid;
  logic                  anyHit;
  logic [BP_IDX_W-1:0]   hitIdx;
  logic                  bpMatch;

  state_t               state;
  state_t               nextState;
  logic [DIV_WIDTH-1:0] divCnt;
  logic                 skipOnce;
  logic                 setSkip;
  logic                 latchHit;
  logic [BP_IDX_W-1:0]  bpHitIdx;
  logic                 cpuEn;
  logic                 boundary;

  // Two-flop synchronizers; step/run resets to step so nothing runs
  // before the real switch position has been seen.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      btnSync     <= 2'b00;
      instrSync   <= 2'b00;
      bpEnSync    <= 2'b00;
      stepRunSync <= 2'b11;
    end else begin
      btnSync     <= {btnSync[0], i_btnStep};
      instrSync   <= {instrSync[0], i_swInstrNCycle};
      bpEnSync    <= {bpEnSync[0], i_swEnableBreakpoint};
      stepRunSync <= {stepRunSync[0], i_swStepNRun};
    end
  end

  assign btnS     = btnSync[1];
  assign instrS   = instrSync[1];
  assign bpEnS    = bpEnSync[1];
  assign stepRunS = stepRunSync[1];

  // Debounce: accept a new level after DEBOUNCE_CYCLES stable cycles,
  // and pulse stepReq on an accepted press.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      dbCnt   <= '0;
      dbLevel <= 1'b0;
      stepReq <= 1'b0;
    end else begin
      stepReq <= 1'b0;
      if (btnS == dbLevel) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_LAST) begin
        dbLevel <= btnS;
        dbCnt   <= '0;
        stepReq <= btnS;
      end else begin
        dbCnt <= dbCnt + DB_W'(1);
      end
    end
  end

  // Breakpoint table write; a same-cycle compare still sees old contents.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_BREAKPOINTS; k++) begin
        bpAddr[k]  <= '0;
        bpValid[k] <= 1'b0;
      end
    end else if (i_bpWrEn) begin
      for (int k = 0; k < NUM_BREAKPOINTS; k++) begin
        if (i_bpIdx == BP_IDX_W'(k)) begin
          bpAddr[k]  <= i_bpAddr;
          bpValid[k] <= i_bpValid;
        end
      end
    end
  end

  // Compare all entries against the PC; the lowest matching index wins.
  always_comb begin
    anyHit = 1'b0;
    hitIdx = '0;
    for (int k = NUM_BREAKPOINTS - 1; k >= 0; k--) begin
      if (bpValid[k] && (bpAddr[k] == i_pc)) begin
        anyHit = 1'b1;
        hitIdx = BP_IDX_W'(k);
      end
    end
  end

  assign bpMatch = bpEnS & anyHit & ~skipOnce;

  assign cpuEn = (state == STEP_CYCLE) |
                 (state == STEP_INSTR) |
                 ((state == RUN) && (divCnt == '0));

  assign boundary = i_instrDone & cpuEn;

  // Next-state decode for the debug FSM.
  always_comb begin
    nextState = state;
    setSkip   = 1'b0;
    latchHit  = 1'b0;
    case (state)
      STOPPED: begin
        if (!stepRunS) begin
          nextState = RUN;
        end else if (stepReq) begin
          nextState = instrS ? STEP_INSTR : STEP_CYCLE;
        end
      end
      STEP_CYCLE: begin
        nextState = STOPPED;
      end
      STEP_INSTR: begin
        if (i_instrDone) begin
          nextState = STOPPED;
        end
      end
      RUN: begin
        if (boundary) begin
          if (bpMatch) begin
            nextState = BREAK;
            latchHit  = 1'b1;
          end else if (stepRunS) begin
            nextState = STOPPED;
          end
        end
      end
      BREAK: begin
        if (stepReq) begin
          nextState = RUN;
          setSkip   = 1'b1;
        end else if (stepRunS) begin
          nextState = STOPPED;
        end
      end
      default: begin
        nextState = STOPPED;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      state <= STOPPED;
    end else begin
      state <= nextState;
    end
  end

  // Run-rate divider; held at zero outside RUN so entry enables at once.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      divCnt <= '0;
    end else if ((state == RUN) && (nextState == RUN)) begin
      if (divCnt == '0) begin
        divCnt <= i_runDiv;
      end else begin
        divCnt <= divCnt - DIV_WIDTH'(1);
      end
    end else begin
      divCnt <= '0;
    end
  end

  // Skip-once lets a resume step past the breakpoint it stopped on.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      skipOnce <= 1'b0;
    end else if (setSkip) begin
      skipOnce <= 1'b1;
    end else if (boundary) begin
      skipOnce <= 1'b0;
    end
  end

  // Remember which breakpoint caused the last halt.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      bpHitIdx <= '0;
    end else if (latchHit) begin
      bpHitIdx <= hitIdx;
    end
  end

`ifdef RUNCTRL_CYCLE_COUNTER_EN
  logic [31:0] cycleCount;

  // Saturating count of enabled cycles; clear wins over increment.
  always_ff @(posedge i_oszClk or posedge i_reset) begin
    if (i_reset) begin
      cycleCount <= '0;
    end else if (i_clrCount) begin
      cycleCount <= '0;
    end else if (cpuEn && (cycleCount != 32'hFFFF_FFFF)) begin
      cycleCount <= cycleCount + 32'd1;
    end
  end

  assign o_cycleCount = cycleCount;
`else
  logic unusedClrCount;
  assign unusedClrCount = i_clrCount;
  assign o_cycleCount   = '0;
`endif

  assign o_cpuEn    = cpuEn;
  assign o_halted   = (state == BREAK);
  assign o_bpHitIdx = bpHitIdx;
  assign o_state    = state;

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed and random checks of run_controller
// against a timeline-based reference model.
module tb_run_controller;

  localparam int AW  = 16;
  localparam int NBP = 4;
  localparam int DB  = 4;
  localparam int DW  = 8;

  localparam int M_STOP = 0;
  localparam int M_CYC  = 1;
  localparam int M_INS  = 2;
  localparam int M_RUN  = 3;
  localparam int M_BRK  = 4;

`ifdef RUNCTRL_CYCLE_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
  localparam int RATE_CNT = 10;
`else
  localparam bit CNT_ON = 1'b0;
  localparam int RATE_CNT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b0;
  logic          swInstr = 1'b0;
  logic          swStepRun = 1'b1;
  logic          swBp = 1'b0;
  logic          instrDone = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          bpWrEn = 1'b0;
  logic [1:0]    bpIdx = '0;
  logic [AW-1:0] bpAddr = '0;
  logic          bpValid = 1'b0;
  logic [DW-1:0] runDiv = '0;
  logic          clrCount = 1'b0;

  logic          cpuEn;
  logic          halted;
  logic [1:0]    hitIdx;
  logic [2:0]    state;
  logic [31:0]   cycleCount;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  run_controller #(
    .ADDR_WIDTH(AW),
    .NUM_BREAKPOINTS(NBP),
    .DEBOUNCE_CYCLES(DB),
    .DIV_WIDTH(DW)
  ) dut (
    .i_oszClk(clk),
    .i_reset(rst),
    .i_btnStep(btn),
    .i_swInstrNCycle(swInstr),
    .i_swStepNRun(swStepRun),
    .i_swEnableBreakpoint(swBp),
    .i_instrDone(instrDone),
    .i_pc(pc),
    .i_bpWrEn(bpWrEn),
    .i_bpIdx(bpIdx),
    .i_bpAddr(bpAddr),
    .i_bpValid(bpValid),
    .i_runDiv(runDiv),
    .i_clrCount(clrCount),
    .o_cpuEn(cpuEn),
    .o_halted(halted),
    .o_bpHitIdx(hitIdx),
    .o_state(state),
    .o_cycleCount(cycleCount)
  );

  // reference model: edge-indexed timeline
  int        n;
  int        mMode;
  int        mNextEn;
  bit        mSkip;
  int        mHit;
  bit        mBpV [NBP];
  int        mBpA [NBP];
  bit [31:0] mCount;
  bit        mAcc;
  bit        mLastS;
  int        mRunLen;
  bit        mReq;
  bit        mEn;
  bit        hRun [$];
  bit        hIns [$];
  bit        hBp [$];
  bit        hBtn [$];

  task automatic checkEq(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    n = 0;
    mMode = M_STOP;
    mNextEn = -1;
    mSkip = 1'b0;
    mHit = 0;
    for (int k = 0; k < NBP; k++) begin
      mBpV[k] = 1'b0;
      mBpA[k] = 0;
    end
    mCount = '0;
    mAcc = 1'b0;
    mLastS = 1'b0;
    mRunLen = 0;
    mReq = 1'b0;
    mEn = 1'b0;
    hRun.delete();
    hIns.delete();
    hBp.delete();
    hBtn.delete();
  endtask

  task automatic modelEdge();
    bit en;
    bit bnd;
    bit req;
    bit sRun;
    bit sIns;
    bit sBp;
    bit sBtn;
    int hit;
    en  = mEn;
    bnd = instrDone && en;
    req = mReq;
    sRun = (n >= 2) ? hRun[n-2] : 1'b1;
    sIns = (n >= 2) ? hIns[n-2] : 1'b0;
    sBp  = (n >= 2) ? hBp[n-2] : 1'b0;
    sBtn = (n >= 2) ? hBtn[n-2] : 1'b0;
    hRun.push_back(swStepRun);
    hIns.push_back(swInstr);
    hBp.push_back(swBp);
    hBtn.push_back(btn);
    hit = -1;
    if (sBp && !mSkip) begin
      for (int k = 0; k < NBP; k++) begin
        if (mBpV[k] && mBpA[k] == int'(pc)) begin
          hit = k;
          break;
        end
      end
    end
    if (bnd) mSkip = 1'b0;
    case (mMode)
      M_STOP: begin
        if (!sRun) begin
          mMode = M_RUN;
          mNextEn = n + 1;
        end else if (req) begin
          mMode = sIns ? M_INS : M_CYC;
        end
      end
      M_CYC: mMode = M_STOP;
      M_INS: if (instrDone) mMode = M_STOP;
      M_RUN: begin
        if (en) mNextEn = n + 1 + int'(runDiv);
        if (bnd) begin
          if (hit >= 0) begin
            mMode = M_BRK;
            mHit = hit;
          end else if (sRun) begin
            mMode = M_STOP;
          end
        end
      end
      M_BRK: begin
        if (req) begin
          mMode = M_RUN;
          mSkip = 1'b1;
          mNextEn = n + 1;
        end else if (sRun) begin
          mMode = M_STOP;
        end
      end
      default: mMode = M_STOP;
    endcase
    if (CNT_ON) begin
      if (clrCount) mCount = '0;
      else if (en && mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
    end
    if (bpWrEn) begin
      mBpV[int'(bpIdx)] = bpValid;
      mBpA[int'(bpIdx)] = int'(bpAddr);
    end
    if (sBtn == mLastS) mRunLen++;
    else mRunLen = 1;
    mLastS = sBtn;
    mReq = 1'b0;
    if (sBtn != mAcc && mRunLen == DB) begin
      mAcc = sBtn;
      mReq = sBtn;
    end
    mEn = (mMode == M_CYC) || (mMode == M_INS) ||
          (mMode == M_RUN && mNextEn == n + 1);
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkEq("cpuEn", 32'(cpuEn), 32'(mEn));
    checkEq("state", 32'(state), 32'(mMode));
    checkEq("halted", 32'(halted), 32'(mMode == M_BRK));
    checkEq("hitIdx", 32'(hitIdx), 32'(mHit));
    checkEq("count", cycleCount, mCount);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic boundaryAt(input logic [AW-1:0] a);
    int g;
    g = 0;
    while (!cpuEn && g < 8) begin
      tick();
      g++;
    end
    checkEq("waitEn", 32'(cpuEn), 32'd1);
    instrDone = 1'b1;
    pc = a;
    tick();
    instrDone = 1'b0;
  endtask

  task automatic pressResume();
    int g;
    g = 0;
    btn = 1'b1;
    while (state != 3'd3 && g < 12) begin
      tick();
      g++;
    end
    btn = 1'b0;
    checkEq("resume", 32'(state), 32'd3);
  endtask

  task automatic writeBp(input int idx, input logic [AW-1:0] a,
                         input logic v);
    bpWrEn = 1'b1;
    bpIdx = 2'(idx);
    bpAddr = a;
    bpValid = v;
    tick();
    bpWrEn = 1'b0;
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkEq("rstEn", 32'(cpuEn), 32'd0);
    checkEq("rstState", 32'(state), 32'd0);
    checkEq("rstHalt", 32'(halted), 32'd0);
    checkEq("rstCount", cycleCount, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  logic [AW-1:0] pcSet [4];

  initial begin
    int pulses;
    int at;
    int enCnt;
    int g;
    pcSet[0] = 16'h0040;
    pcSet[1] = 16'h0100;
    pcSet[2] = 16'h0044;
    pcSet[3] = 16'h0200;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("resetEn", 32'(cpuEn), 32'd0);
    checkEq("resetState", 32'(state), 32'd0);
    checkEq("resetHalt", 32'(halted), 32'd0);
    checkEq("resetIdx", 32'(hitIdx), 32'd0);
    checkEq("resetCount", cycleCount, 32'd0);
    rst = 1'b0;
    modelReset();
    idle(4);

    // cycle step, button held 12 cycles
    pulses = 0;
    at = -1;
    btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpuEn) begin
        pulses++;
        at = i;
      end
    end
    btn = 1'b0;
    checkEq("stepPulses", 32'(pulses), 32'd1);
    checkEq("stepAt", 32'(at), 32'd6);
    idle(10);

    // two-cycle glitch
    pulses = 0;
    btn = 1'b1;
    tick();
    tick();
    btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpuEn) pulses++;
    end
    checkEq("glitch", 32'(pulses), 32'd0);

    // instruction step ending on third enabled cycle
    swInstr = 1'b1;
    idle(3);
    enCnt = 0;
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      instrDone = 1'b0;
      if (cpuEn) begin
        enCnt++;
        if (enCnt == 3) instrDone = 1'b1;
      end
      btn = (i < 7);
    end
    instrDone = 1'b0;
    checkEq("instrEn", 32'(enCnt), 32'd3);
    checkEq("instrState", 32'(state), 32'd0);

    // rate divider
    swInstr = 1'b0;
    runDiv = 8'd2;
    clrCount = 1'b1;
    tick();
    clrCount = 1'b0;
    swStepRun = 1'b0;
    g = 0;
    while (state != 3'd3 && g < 10) begin
      tick();
      g++;
    end
    checkEq("enterRun", 32'(state), 32'd3);
    enCnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (cpuEn) enCnt++;
      tick();
    end
    checkEq("rateEn", 32'(enCnt), 32'd10);
    checkEq("rateCount", cycleCount, 32'(RATE_CNT));

    // breakpoint hit and skip-once resume
    swBp = 1'b1;
    writeBp(2, 16'h0040, 1'b1);
    idle(3);
    boundaryAt(16'h0040);
    checkEq("bpState", 32'(state), 32'd4);
    checkEq("bpHalt", 32'(halted), 32'd1);
    checkEq("bpIdx", 32'(hitIdx), 32'd2);
    checkEq("bpEn", 32'(cpuEn), 32'd0);
    pressResume();
    boundaryAt(16'h0040);
    checkEq("skipOnce", 32'(state), 32'd3);
    boundaryAt(16'h0040);
    checkEq("rebreak", 32'(state), 32'd4);

    // lowest index wins
    writeBp(1, 16'h0100, 1'b1);
    writeBp(3, 16'h0100, 1'b1);
    pressResume();
    boundaryAt(16'h0044);
    checkEq("noMatch", 32'(state), 32'd3);
    boundaryAt(16'h0100);
    checkEq("prioState", 32'(state), 32'd4);
    checkEq("prioIdx", 32'(hitIdx), 32'd1);

    // breakpoints disabled
    swBp = 1'b0;
    idle(3);
    pressResume();
    boundaryAt(16'h0100);
    boundaryAt(16'h0100);
    boundaryAt(16'h0040);
    checkEq("bpOff", 32'(state), 32'd3);
    checkEq("bpOffHalt", 32'(halted), 32'd0);

    // async reset mid-run, then table must be empty
    swBp = 1'b1;
    doReset();
    idle(4);
    checkEq("rerun", 32'(state), 32'd3);
    boundaryAt(16'h0040);
    checkEq("bpCleared", 32'(state), 32'd3);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      if ($urandom_range(0, 59) == 0) swStepRun = ~swStepRun;
      if ($urandom_range(0, 29) == 0) swInstr = ~swInstr;
      if ($urandom_range(0, 49) == 0) swBp = ~swBp;
      instrDone = ($urandom_range(0, 2) == 0);
      pc = pcSet[$urandom_range(0, 3)];
      bpWrEn = ($urandom_range(0, 7) == 0);
      bpIdx = 2'($urandom_range(0, 3));
      bpAddr = pcSet[$urandom_range(0, 3)];
      bpValid = 1'($urandom_range(0, 1));
      runDiv = 8'($urandom_range(0, 3));
      clrCount = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 699) == 0) doReset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
